// File: rtl/dmem_pkg.sv
// Shared types and geometry for the commit-stage data memory responder.
// Word, address and cache/TLB sizing live here so every file agrees.
package dmem_pkg;

   localparam int VA_W            = 32;
   localparam int PA_W            = 32;
   localparam int WORD_W          = 32;
   localparam int REG_W           = 32;

   localparam int NUM_TLB_ENTRIES = 4;
   localparam int NUM_LINES       = 4;
   localparam int LINE_WORDS      = 4;
   localparam int PAGE_OFFSET_W   = 12;

   localparam int LINE_W     = LINE_WORDS * WORD_W;
   localparam int BYTE_OFF_W = $clog2(WORD_W / 8);
   localparam int WORD_OFF_W = $clog2(LINE_WORDS);
   localparam int OFFSET_W   = BYTE_OFF_W + WORD_OFF_W;
   localparam int INDEX_W    = $clog2(NUM_LINES);
   localparam int TAG_W      = PA_W - INDEX_W - OFFSET_W;
   localparam int VPN_W      = VA_W - PAGE_OFFSET_W;
   localparam int PPN_W      = PA_W - PAGE_OFFSET_W;
   localparam int TLB_IDX_W  = $clog2(NUM_TLB_ENTRIES);

   typedef enum logic [1:0] {
      IDLE,
      EVICT,
      FILL
   } state_e;

   typedef enum logic {
      CACHE_BYTE,
      CACHE_WORD
   } cache_mode_e;

   typedef logic [LINE_W-1:0] line_t;

   typedef struct packed {
      logic             valid;
      logic [VPN_W-1:0] vpn;
      logic [PPN_W-1:0] ppn;
   } tlb_entry_t;

   function automatic logic [INDEX_W-1:0] pa_index(
      input logic [PA_W-1:0] pa
   );
      return pa[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [TAG_W-1:0] pa_tag(
      input logic [PA_W-1:0] pa
   );
      return pa[PA_W-1 -: TAG_W];
   endfunction

endpackage

// File: rtl/dmem_tlb.sv
// Fully-associative data TLB with round-robin replacement.
// Lookup is combinational; a write becomes visible after the clock edge.
module dmem_tlb
   import dmem_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [VPN_W-1:0] lookup_vpn_i,
   output logic             hit_o,
   output logic [PPN_W-1:0] ppn_o,
   input  logic             we_i,
   input  logic [VPN_W-1:0] wr_vpn_i,
   input  logic [PPN_W-1:0] wr_ppn_i
);

   tlb_entry_t           ent_q [NUM_TLB_ENTRIES];
   logic [TLB_IDX_W-1:0] victim_q;
   logic                 wr_hit;
   logic [TLB_IDX_W-1:0] wr_idx;

   // Match the lookup VPN against every valid entry.
   always_comb begin
      hit_o = 1'b0;
      ppn_o = '0;
      for (int i = 0; i < NUM_TLB_ENTRIES; i++) begin
         if (ent_q[i].valid && ent_q[i].vpn == lookup_vpn_i) begin
            hit_o = 1'b1;
            ppn_o = ent_q[i].ppn;
         end
      end
   end

   // Pick the slot to write: existing mapping, else the victim.
   always_comb begin
      wr_hit = 1'b0;
      wr_idx = victim_q;
      for (int i = 0; i < NUM_TLB_ENTRIES; i++) begin
         if (ent_q[i].valid && ent_q[i].vpn == wr_vpn_i) begin
            wr_hit = 1'b1;
            wr_idx = TLB_IDX_W'(i);
         end
      end
   end

   // Install mappings; only fresh VPNs advance the victim pointer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_TLB_ENTRIES; i++) begin
            ent_q[i] <= '0;
         end
         victim_q <= '0;
      end else if (we_i) begin
         ent_q[wr_idx] <= '{valid: 1'b1, vpn: wr_vpn_i, ppn: wr_ppn_i};
         if (!wr_hit) begin
            victim_q <= victim_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Commit-stage data memory responder: TLB, direct-mapped write-back
// cache and a line-wide miss engine (IDLE -> EVICT -> FILL).
module dmem_responder
   import dmem_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              tlb_enable,
   input  logic              tlb_write,
   input  logic [VA_W-1:0]   tlb_addr,
   input  logic [PA_W-1:0]   tlb_data,
   input  logic              cache_read,
   input  logic              cache_write,
   input  cache_mode_e       cache_mode,
   input  logic [VA_W-1:0]   cache_addr,
   input  logic [REG_W-1:0]  cache_data_in,
   output logic              tlb_hit,
   output logic              cache_hit,
   output logic [WORD_W-1:0] cache_data_out,
   output logic              mem_req,
   output logic              mem_we,
   output logic [PA_W-1:0]   mem_addr,
   output line_t             mem_wdata,
   input  logic              mem_ack,
   input  line_t             mem_rdata
);

   state_e                state_q;
   line_t                 data_q  [NUM_LINES];
   logic [TAG_W-1:0]      tag_q   [NUM_LINES];
   logic [NUM_LINES-1:0]  valid_q;
   logic [NUM_LINES-1:0]  dirty_q;
   logic [INDEX_W-1:0]    miss_idx_q;
   logic [TAG_W-1:0]      miss_tag_q;
   logic [WORD_W-1:0]     dout_q;

   logic                  lk_hit;
   logic [PPN_W-1:0]      lk_ppn;
   logic                  req;
   logic                  xlat_ok;
   logic [PA_W-1:0]       pa;
   logic [INDEX_W-1:0]    idx;
   logic [TAG_W-1:0]      tag;
   logic [WORD_OFF_W-1:0] woff;
   logic [BYTE_OFF_W-1:0] boff;
   line_t                 line;
   logic                  tag_match;
   logic                  miss_start;
   logic [WORD_W-1:0]     rd_word;
   logic [WORD_W-1:0]     rd_data;
   logic [WORD_W-1:0]     wr_word;
   line_t                 wr_line;
   logic                  unused_bits;

   dmem_tlb u_tlb (
      .clk_i        (clk),
      .rst_i        (reset),
      .lookup_vpn_i (cache_addr[VA_W-1:PAGE_OFFSET_W]),
      .hit_o        (lk_hit),
      .ppn_o        (lk_ppn),
      .we_i         (tlb_write),
      .wr_vpn_i     (tlb_addr[VA_W-1:PAGE_OFFSET_W]),
      .wr_ppn_i     (tlb_data[PA_W-1:PAGE_OFFSET_W])
   );

   assign unused_bits = ^{tlb_addr[PAGE_OFFSET_W-1:0],
                          tlb_data[PAGE_OFFSET_W-1:0]};

   assign req     = cache_read | cache_write;
   assign tlb_hit = tlb_enable & lk_hit;
   assign xlat_ok = ~tlb_enable | lk_hit;
   assign pa      = tlb_enable
                  ? {lk_ppn, cache_addr[PAGE_OFFSET_W-1:0]}
                  : cache_addr[PA_W-1:0];

   assign idx  = pa_index(pa);
   assign tag  = pa_tag(pa);
   assign woff = pa[BYTE_OFF_W +: WORD_OFF_W];
   assign boff = pa[BYTE_OFF_W-1:0];
   assign line = data_q[idx];

   assign tag_match  = valid_q[idx] && (tag_q[idx] == tag);
   assign cache_hit  = (state_q == IDLE) && req && xlat_ok && tag_match;
   assign miss_start = (state_q == IDLE) && req && xlat_ok && !tag_match;

   // Select the addressed word/byte and build the updated line.
   always_comb begin
      rd_word = line[int'(woff) * WORD_W +: WORD_W];
      rd_data = (cache_mode == CACHE_WORD)
              ? rd_word
              : WORD_W'(rd_word[{boff, 3'b000} +: 8]);
      wr_word = rd_word;
      if (cache_mode == CACHE_WORD) begin
         wr_word = cache_data_in[WORD_W-1:0];
      end else begin
         wr_word[{boff, 3'b000} +: 8] = cache_data_in[7:0];
      end
      wr_line = line;
      wr_line[int'(woff) * WORD_W +: WORD_W] = wr_word;
   end

   // Load data is live on a read hit, otherwise the last value holds.
   assign cache_data_out = (cache_hit && !cache_write) ? rd_data : dout_q;

   // Cache arrays, miss FSM and registered memory port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         dirty_q    <= '0;
         miss_idx_q <= '0;
         miss_tag_q <= '0;
         dout_q     <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         for (int i = 0; i < NUM_LINES; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         if (cache_hit && !cache_write) begin
            dout_q <= rd_data;
         end
         unique case (state_q)
            IDLE: begin
               if (cache_hit && cache_write) begin
                  data_q[idx]  <= wr_line;
                  dirty_q[idx] <= 1'b1;
               end else if (miss_start) begin
                  miss_idx_q <= idx;
                  miss_tag_q <= tag;
                  mem_req    <= 1'b1;
                  if (valid_q[idx] && dirty_q[idx]) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= {tag_q[idx], idx, {OFFSET_W{1'b0}}};
                     mem_wdata <= line;
                     state_q   <= EVICT;
                  end else begin
                     mem_we   <= 1'b0;
                     mem_addr <= {tag, idx, {OFFSET_W{1'b0}}};
                     state_q  <= FILL;
                  end
               end
            end
            EVICT: begin
               if (mem_ack) begin
                  dirty_q[miss_idx_q] <= 1'b0;
                  mem_we   <= 1'b0;
                  mem_addr <= {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
                  state_q  <= FILL;
               end
            end
            FILL: begin
               if (mem_ack) begin
                  data_q[miss_idx_q]  <= mem_rdata;
                  tag_q[miss_idx_q]   <= miss_tag_q;
                  valid_q[miss_idx_q] <= 1'b1;
                  dirty_q[miss_idx_q] <= 1'b0;
                  mem_req <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: TLB, hit path, miss FSM.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic              clk;
   logic              reset;
   logic              tlb_enable;
   logic              tlb_write;
   logic [VA_W-1:0]   tlb_addr;
   logic [PA_W-1:0]   tlb_data;
   logic              cache_read;
   logic              cache_write;
   cache_mode_e       cache_mode;
   logic [VA_W-1:0]   cache_addr;
   logic [REG_W-1:0]  cache_data_in;
   logic              tlb_hit;
   logic              cache_hit;
   logic [WORD_W-1:0] cache_data_out;
   logic              mem_req;
   logic              mem_we;
   logic [PA_W-1:0]   mem_addr;
   line_t             mem_wdata;
   logic              mem_ack;
   line_t             mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   dmem_responder dut (
      .clk            (clk),
      .reset          (reset),
      .tlb_enable     (tlb_enable),
      .tlb_write      (tlb_write),
      .tlb_addr       (tlb_addr),
      .tlb_data       (tlb_data),
      .cache_read     (cache_read),
      .cache_write    (cache_write),
      .cache_mode     (cache_mode),
      .cache_addr     (cache_addr),
      .cache_data_in  (cache_data_in),
      .tlb_hit        (tlb_hit),
      .cache_hit      (cache_hit),
      .cache_data_out (cache_data_out),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++; $display("FAIL rst_req: got %0h want 0", mem_req);
      end
      n_cmp++;
      if (cache_data_out !== 32'h0) begin
         n_err++; $display("FAIL rst_dout: got %h want 0", cache_data_out);
      end
      // start a bare miss, then reset mid-cycle
      cache_mode = CACHE_WORD;
      cache_addr = 32'h200;
      cache_read = 1'b1;
      @(negedge clk); #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
         n_err++;
         $display("FAIL pre_rst_fill: got req %0h addr %h want 1 200",
                  mem_req, mem_addr);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
         n_err++;
         $display("FAIL async_rst: got req %0h we %0h addr %h want 0 0 0",
                  mem_req, mem_we, mem_addr);
      end
      n_cmp++;
      if (mem_wdata !== '0) begin
         n_err++; $display("FAIL async_rst_wdata: got %h want 0", mem_wdata);
      end
      @(negedge clk);
      cache_read = 1'b0;
      reset = 1'b0;
      // translation fault on an empty TLB
      @(negedge clk);
      tlb_enable = 1'b1;
      cache_addr = 32'h5008;
      cache_read = 1'b1;
      #1;
      n_cmp++;
      if (tlb_hit !== 1'b0 || cache_hit !== 1'b0) begin
         n_err++;
         $display("FAIL fault_comb: got tlb %0h hit %0h want 0 0",
                  tlb_hit, cache_hit);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++; $display("FAIL fault_req: got %0h want 0", mem_req);
      end
      cache_read = 1'b0;
      tlb_enable = 1'b0;
   endtask

   task automatic test_tlb_map();
      @(negedge clk);
      tlb_write = 1'b1;
      tlb_addr  = 32'h0000_5000;
      tlb_data  = 32'h0001_2000;
      @(negedge clk);
      tlb_write  = 1'b0;
      tlb_enable = 1'b1;
      cache_addr = 32'h0000_5008;
      cache_mode = CACHE_WORD;
      cache_read = 1'b1;
      #1;
      n_cmp++;
      if (tlb_hit !== 1'b1 || cache_hit !== 1'b0) begin
         n_err++;
         $display("FAIL map_lookup: got tlb %0h hit %0h want 1 0",
                  tlb_hit, cache_hit);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 ||
          mem_addr !== 32'h0001_2000) begin
         n_err++;
         $display("FAIL map_fill: got req %0h we %0h addr %h want 1 0 12000",
                  mem_req, mem_we, mem_addr);
      end
      mem_rdata = {32'h4, 32'h3, 32'h2, 32'h1};
      mem_ack   = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      n_cmp++;
      if (cache_hit !== 1'b1 || cache_data_out !== 32'h3 ||
          mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL map_hit: got hit %0h data %h req %0h want 1 3 0",
                  cache_hit, cache_data_out, mem_req);
      end
      @(negedge clk);
      cache_read = 1'b0;
      tlb_enable = 1'b0;
   endtask

   task automatic test_cold_read();
      @(negedge clk);
      cache_addr = 32'h100;
      cache_mode = CACHE_WORD;
      cache_read = 1'b1;
      #1;
      n_cmp++;
      if (cache_hit !== 1'b0) begin
         n_err++; $display("FAIL cold_first: got %0h want 0", cache_hit);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
         n_err++;
         $display("FAIL cold_fill: got req %0h we %0h addr %h want 1 0 100",
                  mem_req, mem_we, mem_addr);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (cache_hit !== 1'b0 || mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL cold_wait%0d: got hit %0h req %0h want 0 1",
                     i, cache_hit, mem_req);
         end
      end
      mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
      mem_ack   = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      n_cmp++;
      if (cache_hit !== 1'b1 || cache_data_out !== 32'hA) begin
         n_err++;
         $display("FAIL cold_hit: got hit %0h data %h want 1 a",
                  cache_hit, cache_data_out);
      end
      @(negedge clk);
      cache_read = 1'b0;
      #1;
      n_cmp++;
      if (cache_hit !== 1'b0 || cache_data_out !== 32'hA) begin
         n_err++;
         $display("FAIL cold_hold: got hit %0h data %h want 0 a",
                  cache_hit, cache_data_out);
      end
   endtask

   task automatic test_byte_write();
      @(negedge clk);
      cache_write   = 1'b1;
      cache_mode    = CACHE_WORD;
      cache_addr    = 32'h100;
      cache_data_in = 32'h1122_3344;
      #1;
      n_cmp++;
      if (cache_hit !== 1'b1) begin
         n_err++; $display("FAIL wr_word_hit: got %0h want 1", cache_hit);
      end
      @(negedge clk);
      cache_mode    = CACHE_BYTE;
      cache_addr    = 32'h101;
      cache_data_in = 32'hFFFF_FFEF;
      @(negedge clk);
      cache_write = 1'b0;
      cache_read  = 1'b1;
      cache_mode  = CACHE_WORD;
      cache_addr  = 32'h100;
      #1;
      n_cmp++;
      if (cache_data_out !== 32'h1122_EF44) begin
         n_err++;
         $display("FAIL byte_merge: got %h want 1122ef44", cache_data_out);
      end
      @(negedge clk);
      cache_mode = CACHE_BYTE;
      cache_addr = 32'h103;
      #1;
      n_cmp++;
      if (cache_data_out !== 32'h0000_0011) begin
         n_err++; $display("FAIL byte_read: got %h want 11", cache_data_out);
      end
      @(negedge clk);
      cache_mode = CACHE_WORD;
      cache_addr = 32'h106;
      #1;
      n_cmp++;
      if (cache_data_out !== 32'hB) begin
         n_err++; $display("FAIL word1_read: got %h want b", cache_data_out);
      end
   endtask

   task automatic test_read_write_both();
      @(negedge clk);
      cache_read    = 1'b1;
      cache_write   = 1'b1;
      cache_mode    = CACHE_WORD;
      cache_addr    = 32'h108;
      cache_data_in = 32'h55;
      #1;
      n_cmp++;
      if (cache_hit !== 1'b1 || cache_data_out !== 32'hB) begin
         n_err++;
         $display("FAIL rw_as_write: got hit %0h data %h want 1 b",
                  cache_hit, cache_data_out);
      end
      @(negedge clk);
      cache_write = 1'b0;
      #1;
      n_cmp++;
      if (cache_data_out !== 32'h55) begin
         n_err++; $display("FAIL rw_readback: got %h want 55", cache_data_out);
      end
      @(negedge clk);
      cache_read = 1'b0;
   endtask

   task automatic test_evict();
      line_t dirty_line;
      dirty_line = {32'hD, 32'h55, 32'hB, 32'h1122_EF44};
      @(negedge clk);
      cache_read = 1'b1;
      cache_mode = CACHE_WORD;
      cache_addr = 32'h100 + NUM_LINES * LINE_WORDS * 4;
      #1;
      n_cmp++;
      if (cache_hit !== 1'b0) begin
         n_err++; $display("FAIL ev_miss: got %0h want 0", cache_hit);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100) begin
         n_err++;
         $display("FAIL ev_req: got req %0h we %0h addr %h want 1 1 100",
                  mem_req, mem_we, mem_addr);
      end
      n_cmp++;
      if (mem_wdata !== dirty_line) begin
         n_err++;
         $display("FAIL ev_wdata: got %h want %h", mem_wdata, dirty_line);
      end
      mem_ack = 1'b1;
      @(negedge clk); #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h140 ||
          cache_hit !== 1'b0) begin
         n_err++;
         $display("FAIL ev_fill: got req %0h we %0h addr %h hit %0h want 1 0 140 0",
                  mem_req, mem_we, mem_addr, cache_hit);
      end
      mem_rdata = {32'h44, 32'h33, 32'h22, 32'h11};
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      n_cmp++;
      if (cache_hit !== 1'b1 || cache_data_out !== 32'h11 ||
          mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL ev_hit: got hit %0h data %h req %0h want 1 11 0",
                  cache_hit, cache_data_out, mem_req);
      end
      @(negedge clk);
      cache_read = 1'b0;
   endtask

   task automatic test_flush();
      @(negedge clk);
      cache_read = 1'b1;
      cache_mode = CACHE_WORD;
      cache_addr = 32'h100;
      @(negedge clk); #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
         n_err++;
         $display("FAIL fl_fill: got req %0h we %0h addr %h want 1 0 100",
                  mem_req, mem_we, mem_addr);
      end
      cache_read = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
         n_err++;
         $display("FAIL fl_hold: got req %0h addr %h want 1 100",
                  mem_req, mem_addr);
      end
      mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
      mem_ack   = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++; $display("FAIL fl_done: got req %0h want 0", mem_req);
      end
      repeat (2) @(negedge clk);
      cache_read = 1'b1;
      cache_addr = 32'h10C;
      #1;
      n_cmp++;
      if (cache_hit !== 1'b1 || cache_data_out !== 32'hD) begin
         n_err++;
         $display("FAIL fl_hit: got hit %0h data %h want 1 d",
                  cache_hit, cache_data_out);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++; $display("FAIL fl_noreq: got %0h want 0", mem_req);
      end
      cache_read = 1'b0;
   endtask

   task automatic test_tlb_rr();
      logic [VA_W-1:0] va_tab [5];
      va_tab = '{32'h5000, 32'h6000, 32'h7000, 32'h8000, 32'h9000};
      // remap 0x5000 in place, then four fresh pages
      @(negedge clk);
      tlb_write = 1'b1;
      tlb_addr  = 32'h5000;
      tlb_data  = 32'h0003_4000;
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         tlb_addr = va_tab[i];
         tlb_data = 32'h0010_0000 + PA_W'(i) * 32'h1000;
      end
      @(negedge clk);
      tlb_write  = 1'b0;
      tlb_enable = 1'b1;
      cache_addr = 32'h5010;
      #1;
      n_cmp++;
      if (tlb_hit !== 1'b0) begin
         n_err++; $display("FAIL rr_evicted: got %0h want 0", tlb_hit);
      end
      cache_addr = 32'h9FFC;
      #1;
      n_cmp++;
      if (tlb_hit !== 1'b1) begin
         n_err++; $display("FAIL rr_newest: got %0h want 1", tlb_hit);
      end
      cache_addr = 32'h6000;
      #1;
      n_cmp++;
      if (tlb_hit !== 1'b1) begin
         n_err++; $display("FAIL rr_kept: got %0h want 1", tlb_hit);
      end
      tlb_enable = 1'b0;
      #1;
      n_cmp++;
      if (tlb_hit !== 1'b0) begin
         n_err++; $display("FAIL bare_nohit: got %0h want 0", tlb_hit);
      end
      // lookup in the write cycle sees the old contents
      @(negedge clk);
      tlb_enable = 1'b1;
      cache_addr = 32'hA008;
      tlb_write  = 1'b1;
      tlb_addr   = 32'hA000;
      tlb_data   = 32'h0007_7000;
      #1;
      n_cmp++;
      if (tlb_hit !== 1'b0) begin
         n_err++; $display("FAIL wr_same_cyc: got %0h want 0", tlb_hit);
      end
      @(negedge clk);
      tlb_write = 1'b0;
      #1;
      n_cmp++;
      if (tlb_hit !== 1'b1) begin
         n_err++; $display("FAIL wr_next_cyc: got %0h want 1", tlb_hit);
      end
      tlb_enable = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      tlb_enable    = 1'b0;
      tlb_write     = 1'b0;
      tlb_addr      = '0;
      tlb_data      = '0;
      cache_read    = 1'b0;
      cache_write   = 1'b0;
      cache_mode    = CACHE_WORD;
      cache_addr    = '0;
      cache_data_in = '0;
      mem_ack       = 1'b0;
      mem_rdata     = '0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (tlb_hit !== 1'b0 || cache_hit !== 1'b0 || mem_we !== 1'b0) begin
         n_err++;
         $display("FAIL in_reset: got tlb %0h hit %0h we %0h want 0 0 0",
                  tlb_hit, cache_hit, mem_we);
      end
      test_reset();
      test_tlb_map();
      test_cold_read();
      test_byte_write();
      test_read_write_both();
      test_evict();
      test_flush();
      test_tlb_rr();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
